// File: rtl/trax_force_scheduler.sv
// Forced-move scheduler: sweeps the board RAM in row-major order, presents each empty cell's
// neighbours to the forced-move checker and writes back forced tiles until a pass is quiet.
module trax_force_scheduler #(
  parameter int unsigned ROWS       = 8,
  parameter int unsigned COLS       = 8,
  parameter int unsigned ADDR_W     = 6,
  parameter int unsigned MAX_PASSES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        error_code,
  output logic [ADDR_W-1:0] error_addr,
  output logic [7:0]        placed_count,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [3:0]        mem_rdata,
  output logic              mem_we,
  output logic [3:0]        mem_wdata,
  output logic [3:0]        chk_left,
  output logic [3:0]        chk_down,
  output logic [3:0]        chk_right,
  output logic [3:0]        chk_up,
  output logic [3:0]        chk_tile,
  input  logic [3:0]        chk_tile_out,
  input  logic              chk_error
);

  localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned PW = $clog2(MAX_PASSES + 1);
  localparam logic [ADDR_W-1:0] LastCell = ADDR_W'(ROWS * COLS - 1);
  localparam logic [ADDR_W-1:0] ColsA    = ADDR_W'(COLS);
  localparam logic [RW-1:0]     LastRow  = RW'(ROWS - 1);
  localparam logic [CW-1:0]     LastCol  = CW'(COLS - 1);
  localparam logic [PW-1:0]     LastPass = PW'(MAX_PASSES - 1);

  typedef enum logic [3:0] {
    StIdle, StRc, StRl, StRd, StRr, StRu, StEv, StWr, StNext, StDone
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cell_q, cell_d, eaddr_q, eaddr_d;
  logic [RW-1:0]     row_q, row_d;
  logic [CW-1:0]     col_q, col_d;
  logic [PW-1:0]     pass_q, pass_d;
  logic              changed_q, changed_d, rd_prev_q;
  logic [3:0]        left_q, left_d, down_q, down_d, right_q, right_d, up_q, up_d;
  logic              busy_q, busy_d, done_q, done_d, we_q, we_d, error_q, error_d;
  logic [3:0]        wdata_q, wdata_d;
  logic [1:0]        code_q, code_d;
  logic [7:0]        placed_q, placed_d;
  logic [3:0]        rd_val;

  // Off-board slots issue no read, so whatever the RAM still drives is masked to empty.
  assign rd_val = rd_prev_q ? mem_rdata : 4'd0;

  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign error_code   = code_q;
  assign error_addr   = eaddr_q;
  assign placed_count = placed_q;
  assign mem_we       = we_q;
  assign mem_wdata    = wdata_q;
  assign chk_left     = left_q;
  assign chk_down     = down_q;
  assign chk_right    = right_q;
  assign chk_up       = (state_q == StEv) ? rd_val : up_q;
  assign chk_tile     = 4'd0;

  // Read strobes depend on the centre tile arriving in RL, so they are decoded combinationally.
  always_comb begin
    mem_rd_en = 1'b0;
    mem_addr  = '0;
    case (state_q)
      StRc: begin
        mem_rd_en = 1'b1;
        mem_addr  = cell_q;
      end
      StRl: if (mem_rdata == 4'd0 && col_q != '0) begin
        mem_rd_en = 1'b1;
        mem_addr  = cell_q - ADDR_W'(1);
      end
      StRd: if (row_q != LastRow) begin
        mem_rd_en = 1'b1;
        mem_addr  = cell_q + ColsA;
      end
      StRr: if (col_q != LastCol) begin
        mem_rd_en = 1'b1;
        mem_addr  = cell_q + ADDR_W'(1);
      end
      StRu: if (row_q != '0) begin
        mem_rd_en = 1'b1;
        mem_addr  = cell_q - ColsA;
      end
      StWr:    mem_addr = cell_q;
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cell_d    = cell_q;
    row_d     = row_q;
    col_d     = col_q;
    pass_d    = pass_q;
    changed_d = changed_q;
    left_d    = left_q;
    down_d    = down_q;
    right_d   = right_q;
    up_d      = up_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    we_d      = 1'b0;
    wdata_d   = wdata_q;
    error_d   = error_q;
    code_d    = code_q;
    eaddr_d   = eaddr_q;
    placed_d  = placed_q;
    case (state_q)
      StIdle: if (start) begin
        state_d   = StRc;
        busy_d    = 1'b1;
        error_d   = 1'b0;
        code_d    = 2'd0;
        eaddr_d   = '0;
        placed_d  = 8'd0;
        cell_d    = '0;
        row_d     = '0;
        col_d     = '0;
        pass_d    = '0;
        changed_d = 1'b0;
      end
      StRc: state_d = StRl;
      StRl: state_d = (mem_rdata != 4'd0) ? StNext : StRd;
      StRd: begin
        left_d  = rd_val;
        state_d = StRr;
      end
      StRr: begin
        down_d  = rd_val;
        state_d = StRu;
      end
      StRu: begin
        right_d = rd_val;
        state_d = StEv;
      end
      StEv: begin
        up_d = rd_val;
        if (chk_error) begin
          error_d = 1'b1;
          code_d  = 2'd1;
          eaddr_d = cell_q;
          done_d  = 1'b1;
          state_d = StDone;
        end else if (chk_tile_out != 4'd0) begin
          we_d    = 1'b1;
          wdata_d = chk_tile_out;
          state_d = StWr;
        end else begin
          state_d = StNext;
        end
      end
      StWr: begin
        placed_d  = (placed_q == 8'hff) ? placed_q : placed_q + 8'd1;
        changed_d = 1'b1;
        state_d   = StNext;
      end
      StNext: begin
        if (cell_q == LastCell) begin
          if (!changed_q) begin
            done_d  = 1'b1;
            state_d = StDone;
          end else if (pass_q == LastPass) begin
            error_d = 1'b1;
            code_d  = 2'd2;
            done_d  = 1'b1;
            state_d = StDone;
          end else begin
            pass_d    = pass_q + PW'(1);
            cell_d    = '0;
            row_d     = '0;
            col_d     = '0;
            changed_d = 1'b0;
            state_d   = StRc;
          end
        end else begin
          cell_d = cell_q + ADDR_W'(1);
          if (col_q == LastCol) begin
            col_d = '0;
            row_d = row_q + RW'(1);
          end else begin
            col_d = col_q + CW'(1);
          end
          state_d = StRc;
        end
      end
      StDone: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cell_q    <= '0;
      row_q     <= '0;
      col_q     <= '0;
      pass_q    <= '0;
      changed_q <= 1'b0;
      rd_prev_q <= 1'b0;
      left_q    <= 4'd0;
      down_q    <= 4'd0;
      right_q   <= 4'd0;
      up_q      <= 4'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      we_q      <= 1'b0;
      wdata_q   <= 4'd0;
      error_q   <= 1'b0;
      code_q    <= 2'd0;
      eaddr_q   <= '0;
      placed_q  <= 8'd0;
    end else begin
      state_q   <= state_d;
      cell_q    <= cell_d;
      row_q     <= row_d;
      col_q     <= col_d;
      pass_q    <= pass_d;
      changed_q <= changed_d;
      rd_prev_q <= mem_rd_en;
      left_q    <= left_d;
      down_q    <= down_d;
      right_q   <= right_d;
      up_q      <= up_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      error_q   <= error_d;
      code_q    <= code_d;
      eaddr_q   <= eaddr_d;
      placed_q  <= placed_d;
    end
  end

endmodule

// File: tb/tb_trax_force_scheduler.sv
// Bench for trax_force_scheduler: board RAM and checker models, plus a pass-by-pass reference
// of the whole scheduling operation computed directly on a board array.
module tb_trax_force_scheduler;
  localparam int N = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, start1 = 1'b0, start2 = 1'b0, sel = 1'b0, load = 1'b0;
  int   mode = 0;

  logic       busy1, done1, err1, rd1, we1, busy2, done2, err2, rd2, we2;
  logic [1:0] code1, code2;
  logic [5:0] eaddr1, addr1, eaddr2, addr2;
  logic [7:0] placed1, placed2;
  logic [3:0] wdata1, cl1, cd1, cr1, cu1, ct1, wdata2, cl2, cd2, cr2, cu2, ct2;
  logic [3:0] mem_rdata, chk_tile_out;
  logic       chk_error;

  trax_force_scheduler u_dut (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1), .error(err1),
    .error_code(code1), .error_addr(eaddr1), .placed_count(placed1), .mem_addr(addr1),
    .mem_rd_en(rd1), .mem_rdata(mem_rdata), .mem_we(we1), .mem_wdata(wdata1),
    .chk_left(cl1), .chk_down(cd1), .chk_right(cr1), .chk_up(cu1), .chk_tile(ct1),
    .chk_tile_out(chk_tile_out), .chk_error(chk_error)
  );

  trax_force_scheduler #(.MAX_PASSES(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2), .error(err2),
    .error_code(code2), .error_addr(eaddr2), .placed_count(placed2), .mem_addr(addr2),
    .mem_rd_en(rd2), .mem_rdata(mem_rdata), .mem_we(we2), .mem_wdata(wdata2),
    .chk_left(cl2), .chk_down(cd2), .chk_right(cr2), .chk_up(cu2), .chk_tile(ct2),
    .chk_tile_out(chk_tile_out), .chk_error(chk_error)
  );

  logic       m_busy, m_done, m_err, m_rd, m_we;
  logic [1:0] m_code;
  logic [5:0] m_eaddr, m_addr;
  logic [7:0] m_placed;
  logic [3:0] m_wdata, m_cl, m_cd, m_cr, m_cu;
  assign m_busy   = sel ? busy2 : busy1;
  assign m_done   = sel ? done2 : done1;
  assign m_err    = sel ? err2 : err1;
  assign m_code   = sel ? code2 : code1;
  assign m_eaddr  = sel ? eaddr2 : eaddr1;
  assign m_placed = sel ? placed2 : placed1;
  assign m_rd     = sel ? rd2 : rd1;
  assign m_we     = sel ? we2 : we1;
  assign m_addr   = sel ? addr2 : addr1;
  assign m_wdata  = sel ? wdata2 : wdata1;
  assign m_cl     = sel ? cl2 : cl1;
  assign m_cd     = sel ? cd2 : cd1;
  assign m_cr     = sel ? cr2 : cr1;
  assign m_cu     = sel ? cu2 : cu1;

  logic [3:0] init_b [N];
  logic [3:0] exp_b  [N];
  logic [3:0] mem    [N];

  // Read data only changes on a read, so skipped slots leave stale data for the DUT to mask.
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < N; i++) mem[i] <= init_b[i];
    end else begin
      if (m_we) mem[m_addr] <= m_wdata;
      if (m_rd) mem_rdata <= mem[m_addr];
    end
  end

  function automatic logic [4:0] chk_fn(input int md, input logic [3:0] l, d, r, u);
    logic [3:0] t;
    logic       e;
    int         nz;
    t  = 4'd0;
    e  = 1'b0;
    nz = 0;
    case (md)
      1: begin
        if (l != 0) nz++;
        if (d != 0) nz++;
        if (r != 0) nz++;
        if (u != 0) nz++;
        if (l == 6 && r == 6 && u == 6) e = 1'b1;
        else if (nz >= 2) t = 4'((int'(l) + int'(d) + int'(r) + int'(u)) % 6 + 1);
      end
      2: if (l == 1 && d == 1) t = 4'd2;
      3: if (u == 5) e = 1'b1; else if (r == 4) t = 4'd3;
      4: if (r != 0) t = 4'd1;
      default: ;
    endcase
    return {e, t};
  endfunction

  always_comb {chk_error, chk_tile_out} = chk_fn(mode, m_cl, m_cd, m_cr, m_cu);

  int n_checks = 0, n_pass = 0;
  int exp_placed, exp_err, exp_code, exp_eaddr, exp_cycles;
  int exp_wr[$], got_wr[$];
  int got_cycles, timed_out, overlap, busy_low;

  // Reference: whole passes over a plain board array, costing 3/7/8 cycles per cell.
  task automatic model_run(input int md, input int maxp);
    logic [3:0] l, d, r, u;
    logic [4:0] res;
    bit stop, changed;
    for (int i = 0; i < N; i++) exp_b[i] = init_b[i];
    exp_placed = 0; exp_err = 0; exp_code = 0; exp_eaddr = 0; exp_cycles = 0;
    exp_wr.delete();
    stop = 0;
    for (int p = 0; !stop; p++) begin
      changed = 0;
      for (int c = 0; c < N && !stop; c++) begin
        if (exp_b[c] != 0) begin
          exp_cycles += 3;
          continue;
        end
        l = (c % 8 != 0) ? exp_b[c-1] : 4'd0;
        d = (c / 8 != 7) ? exp_b[c+8] : 4'd0;
        r = (c % 8 != 7) ? exp_b[c+1] : 4'd0;
        u = (c / 8 != 0) ? exp_b[c-8] : 4'd0;
        res = chk_fn(md, l, d, r, u);
        if (res[4]) begin
          exp_cycles += 6; exp_err = 1; exp_code = 1; exp_eaddr = c; stop = 1;
        end else if (res[3:0] != 0) begin
          exp_b[c] = res[3:0];
          if (exp_placed < 255) exp_placed++;
          changed = 1;
          exp_cycles += 8;
          exp_wr.push_back(c * 16 + int'(res[3:0]));
        end else begin
          exp_cycles += 7;
        end
      end
      if (!stop) begin
        if (!changed) stop = 1;
        else if (p + 1 == maxp) begin
          exp_err = 1; exp_code = 2; stop = 1;
        end
      end
    end
  endtask

  task automatic load_board();
    @(negedge clk); load = 1'b1;
    @(negedge clk); load = 1'b0;
  endtask

  task automatic clear_init();
    for (int i = 0; i < N; i++) init_b[i] = 4'd0;
  endtask

  // Starts one operation and follows it to DONE; cycle 0 is the first RC.
  task automatic run_op(input bit s2, input int budget);
    int n;
    got_wr.delete();
    timed_out = 0; overlap = 0; busy_low = 0; n = 0;
    @(negedge clk);
    sel = s2;
    if (s2) start2 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; start2 = 1'b0;
    forever begin
      if (m_rd && m_we) overlap++;
      if (!m_busy) busy_low++;
      if (m_we) got_wr.push_back(int'(m_addr) * 16 + int'(m_wdata));
      if (m_done) break;
      if (n >= budget) begin
        timed_out = 1;
        break;
      end
      @(negedge clk);
      n++;
    end
    got_cycles = n;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if ({busy1, done1, err1, rd1, we1} !== 5'b0) $display("FAIL reset_ctrl: got %b want 00000", {busy1, done1, err1, rd1, we1}); else n_pass++;
    n_checks++; if ({code1, eaddr1, placed1, addr1, wdata1} !== '0) $display("FAIL reset_data: got %h want 0", {code1, eaddr1, placed1, addr1, wdata1}); else n_pass++;
    n_checks++; if ({cl1, cd1, cr1, cu1, ct1} !== 20'd0) $display("FAIL reset_chk: got %h want 0", {cl1, cd1, cr1, cu1, ct1}); else n_pass++;
    n_checks++; if ({busy2, done2, err2, rd2, we2, code2, placed2, ct2} !== '0) $display("FAIL reset_dut2: got %h want 0", {busy2, done2, err2, rd2, we2, code2, placed2, ct2}); else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_empty_board();
    clear_init(); mode = 0; load_board();
    run_op(0, 2000);
    n_checks++; if (timed_out !== 0) $display("FAIL empty_timeout: got %0d want 0", timed_out); else n_pass++;
    n_checks++; if (got_cycles !== 448) $display("FAIL empty_cycles: got %0d want 448", got_cycles); else n_pass++;
    n_checks++; if (m_placed !== 8'd0 || m_err !== 1'b0) $display("FAIL empty_result: got placed %0d err %0d want 0 0", m_placed, m_err); else n_pass++;
    n_checks++; if (got_wr.size() !== 0) $display("FAIL empty_writes: got %0d want 0", got_wr.size()); else n_pass++;
    n_checks++; if (busy_low !== 0 || m_busy !== 1'b0) $display("FAIL empty_busy: got low %0d idle %0d want 0 0", busy_low, m_busy); else n_pass++;
  endtask

  task automatic test_forced_write();
    clear_init(); init_b[8] = 4'd1; init_b[17] = 4'd1; mode = 2; load_board();
    model_run(2, 16);
    run_op(0, 4000);
    n_checks++; if (got_wr.size() !== 1 || got_wr[0] !== 9 * 16 + 2) $display("FAIL forced_write: got %0d writes want one of 2 to 9", got_wr.size()); else n_pass++;
    n_checks++; if (m_placed !== 8'd1 || m_err !== 1'b0) $display("FAIL forced_result: got placed %0d err %0d want 1 0", m_placed, m_err); else n_pass++;
    n_checks++; if (got_cycles !== exp_cycles) $display("FAIL forced_cycles: got %0d want %0d", got_cycles, exp_cycles); else n_pass++;
    n_checks++; if (mem[9] !== 4'd2) $display("FAIL forced_mem: got %0d want 2", mem[9]); else n_pass++;
  endtask

  task automatic test_conflict();
    clear_init(); init_b[12] = 4'd5; init_b[11] = 4'd4; init_b[30] = 4'd4; mode = 3; load_board();
    model_run(3, 16);
    run_op(0, 4000);
    n_checks++; if (timed_out !== 0) $display("FAIL conflict_timeout: got %0d want 0", timed_out); else n_pass++;
    n_checks++; if (m_err !== 1'b1 || m_code !== 2'd1 || m_eaddr !== 6'd20) $display("FAIL conflict_flags: got err %0d code %0d addr %0d want 1 1 20", m_err, m_code, m_eaddr); else n_pass++;
    n_checks++; if (got_wr.size() !== 1 || got_wr[0] !== 10 * 16 + 3) $display("FAIL conflict_writes: got %0d writes want one of 3 to 10", got_wr.size()); else n_pass++;
    n_checks++; if (mem[20] !== 4'd0 || mem[29] !== 4'd0) $display("FAIL conflict_mem: got %0d %0d want 0 0", mem[20], mem[29]); else n_pass++;
    n_checks++; if (got_cycles !== exp_cycles || m_placed !== 8'd1) $display("FAIL conflict_cycles: got %0d placed %0d want %0d 1", got_cycles, m_placed, exp_cycles); else n_pass++;
  endtask

  task automatic test_pass_limit();
    clear_init(); init_b[7] = 4'd1; mode = 4; load_board();
    model_run(4, 2);
    run_op(1, 4000);
    n_checks++; if (m_err !== 1'b1 || m_code !== 2'd2) $display("FAIL limit_flags: got err %0d code %0d want 1 2", m_err, m_code); else n_pass++;
    n_checks++; if (m_placed !== 8'd2 || got_wr.size() !== 2) $display("FAIL limit_placed: got %0d writes %0d want 2 2", m_placed, got_wr.size()); else n_pass++;
    n_checks++; if (got_wr.size() == 2 && (got_wr[0] !== 6 * 16 + 1 || got_wr[1] !== 5 * 16 + 1)) $display("FAIL limit_order: got %0d %0d want 97 81", got_wr[0], got_wr[1]); else n_pass++;
    n_checks++; if (got_cycles !== exp_cycles) $display("FAIL limit_cycles: got %0d want %0d", got_cycles, exp_cycles); else n_pass++;
    sel = 1'b0;
  endtask

  task automatic test_corner();
    int n;
    clear_init(); init_b[1] = 4'd3; init_b[8] = 4'd4; mode = 0; load_board();
    @(negedge clk); sel = 1'b0; start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    n_checks++; if (rd1 !== 1'b1 || addr1 !== 6'd0) $display("FAIL corner_rc: got rd %0d addr %0d want 1 0", rd1, addr1); else n_pass++;
    @(negedge clk);
    n_checks++; if (rd1 !== 1'b0) $display("FAIL corner_left_slot: got %0d want 0", rd1); else n_pass++;
    @(negedge clk);
    n_checks++; if (rd1 !== 1'b1 || addr1 !== 6'd8) $display("FAIL corner_down_slot: got rd %0d addr %0d want 1 8", rd1, addr1); else n_pass++;
    @(negedge clk);
    n_checks++; if (rd1 !== 1'b1 || addr1 !== 6'd1) $display("FAIL corner_right_slot: got rd %0d addr %0d want 1 1", rd1, addr1); else n_pass++;
    @(negedge clk);
    n_checks++; if (rd1 !== 1'b0) $display("FAIL corner_up_slot: got %0d want 0", rd1); else n_pass++;
    @(negedge clk);
    n_checks++; if ({cl1, cd1, cr1, cu1, ct1} !== {4'd0, 4'd4, 4'd3, 4'd0, 4'd0}) $display("FAIL corner_ev: got %h want 04300", {cl1, cd1, cr1, cu1, ct1}); else n_pass++;
    n = 0;
    while (!done1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    n_checks++; if (done1 !== 1'b1) $display("FAIL corner_done: got %0d want 1", done1); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_write();
    int n;
    clear_init(); init_b[8] = 4'd1; init_b[17] = 4'd1; mode = 2; load_board();
    @(negedge clk); sel = 1'b0; start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    n = 0;
    while (!we1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    n_checks++; if (we1 !== 1'b1) $display("FAIL rstmid_reach_wr: got %0d want 1", we1); else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if ({we1, busy1, done1, placed1} !== '0) $display("FAIL rstmid_after: got %h want 0", {we1, busy1, done1, placed1}); else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (we1 !== 1'b0 || busy1 !== 1'b0) $display("FAIL rstmid_quiet: got we %0d busy %0d want 0 0", we1, busy1); else n_pass++;
    for (int i = 0; i < N; i++) init_b[i] = mem[i];
    model_run(2, 16);
    run_op(0, 4000);
    n_checks++; if (timed_out !== 0 || m_err !== 1'b0 || m_placed !== 8'(exp_placed)) $display("FAIL rstmid_rerun: got to %0d err %0d placed %0d want 0 0 %0d", timed_out, m_err, m_placed, exp_placed); else n_pass++;
    n_checks++; if (got_cycles !== exp_cycles) $display("FAIL rstmid_cycles: got %0d want %0d", got_cycles, exp_cycles); else n_pass++;
  endtask

  task automatic test_random();
    int bad;
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < N; i++)
        init_b[i] = ($urandom_range(0, 99) < 30) ? 4'($urandom_range(1, 6)) : 4'd0;
      mode = 1; load_board();
      model_run(1, 16);
      run_op(0, 10000);
      n_checks++; if (timed_out !== 0 || overlap !== 0) $display("FAIL rand%0d_run: got timeout %0d overlap %0d want 0 0", it, timed_out, overlap); else n_pass++;
      n_checks++; if (got_cycles !== exp_cycles) $display("FAIL rand%0d_cycles: got %0d want %0d", it, got_cycles, exp_cycles); else n_pass++;
      n_checks++; if (m_placed !== 8'(exp_placed) || m_err !== 1'(exp_err) || m_code !== 2'(exp_code)) $display("FAIL rand%0d_status: got %0d %0d %0d want %0d %0d %0d", it, m_placed, m_err, m_code, exp_placed, exp_err, exp_code); else n_pass++;
      n_checks++; if (exp_err == 1 && exp_code == 1 && m_eaddr !== 6'(exp_eaddr)) $display("FAIL rand%0d_eaddr: got %0d want %0d", it, m_eaddr, exp_eaddr); else n_pass++;
      bad = (got_wr.size() == exp_wr.size()) ? 0 : 1;
      for (int i = 0; i < got_wr.size() && i < exp_wr.size(); i++) if (got_wr[i] != exp_wr[i]) bad++;
      for (int i = 0; i < N; i++) if (mem[i] !== exp_b[i]) bad++;
      n_checks++; if (bad !== 0) $display("FAIL rand%0d_board: got %0d differences want 0", it, bad); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_empty_board();
    test_forced_write();
    test_conflict();
    test_pass_limit();
    test_corner();
    test_reset_mid_write();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/trax_force_scheduler.md
Name: trax_force_scheduler

Overview:
- Sequences the forced-move tile checker across the whole Trax board held in a single-port board RAM.
- After a player move, scans every cell in row-major order. For each empty cell it gathers the four neighbours, drives the combinational forced-move checker, and writes back any forced tile.
- Repeats passes until a pass places nothing, a conflict is detected, or the pass limit is hit.
- Sits between the move-entry logic (start/done) and the board RAM.

Parameters:
- ROWS, 8, board rows; row 0 is the top row.
- COLS, 8, board columns.
- ADDR_W, 6, board RAM address width; must satisfy 2^ADDR_W >= ROWS*COLS.
- MAX_PASSES, 16, maximum full scans per start.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin scheduling; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until the DONE cycle inclusive
- done  out  1  one-cycle pulse at end of operation
- error  out  1  set if the operation ended abnormally; held until next accepted start
- error_code  out  2  0 none, 1 checker conflict, 2 pass limit; held
- error_addr  out  ADDR_W  cell address of the conflict; held
- placed_count  out  8  tiles written this operation; saturates at 255; held
- mem_addr  out  ADDR_W  board RAM address (row*COLS+col)
- mem_rd_en  out  1  read strobe; mem_rdata is valid the following cycle
- mem_rdata  in  4  tile code 0 (empty) or 1..6
- mem_we  out  1  write strobe
- mem_wdata  out  4  tile to write
- chk_left, chk_down, chk_right, chk_up  out  4 each  neighbour tiles to checker
- chk_tile  out  4  centre tile to checker (always 0 during EV)
- chk_tile_out  in  4  checker's forced tile, 0 = none
- chk_error  in  1  checker conflict flag

Behaviour:
- Reset: state IDLE; all outputs 0; neighbour registers, counters and flags cleared. Reset mid-operation aborts with no further writes, and mem_we is 0 from the next cycle.
- States and per-state actions:
  - IDLE: on start, clear error, error_code, error_addr and placed_count; cell=0, pass=0, changed=0; go to RC.
  - RC: issue read of centre cell.
  - RL: capture centre. If centre != 0, go to NEXT. Otherwise issue left-neighbour read and go to RD.
  - RD, RR, RU: each captures the previous read and issues its own neighbour read (down, right, up).
  - EV: capture up; drive chk_* from registers.
    - If chk_error: error=1, code=1, error_addr=cell; go to DONE.
    - Else if chk_tile_out != 0: go to WR.
    - Else: go to NEXT.
  - WR: mem_we=1, mem_wdata=chk_tile_out (registered), mem_addr=cell; placed_count++ (saturating); changed=1; go to NEXT.
  - NEXT: if cell == ROWS*COLS-1, handle end of pass; else cell++ and go to RC.
  - End of pass:
    - changed=0: go to DONE.
    - changed=1 and pass+1 == MAX_PASSES: error=1, code=2; go to DONE.
    - Otherwise pass++, cell=0, changed=0; go to RC.
  - DONE: done=1 for one cycle; return to IDLE.
- Off-board neighbours (row 0 up, last row down, col 0 left, last col right): no read issued (mem_rd_en=0 that cycle), value forced to 0, cycle still spent.
- Fixed cycle counts: occupied cell 3 cycles; empty cell with nothing forced 7 cycles; empty cell with a forced write 8 cycles.
- Writes are visible to later cells in the same pass.
- mem_rd_en and mem_we are never high in the same cycle.
- start outside IDLE is ignored.

Test Plan:
- All-empty 8x8 board, checker always 0 -> exactly one pass; done pulses 448 cycles after the first RC (RC entered the cycle after start); placed_count=0, error=0.
- Cell 9 = 0 with left (cell 8) = 1 and down (cell 17) = 1, checker model returns 2 -> write of 2 to address 9; second pass writes nothing; placed_count=1, done, error=0.
- Checker model asserts chk_error when evaluating cell 20 -> no write to 20 or any later cell; error=1, error_code=1, error_addr=20, done pulse.
- Checker model forces a tile on every pass, with MAX_PASSES=2 -> done after the second pass; error_code=2.
- Corner cell 0 empty -> mem_rd_en low during the left and up read slots; chk_left=0 and chk_up=0 in EV.
- rst asserted in the WR cycle of a forced write -> IDLE next cycle, mem_we=0, busy=0; a subsequent start runs cleanly.
